// File: rtl/id_issue_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// id_issue_ctrl : scoreboard issue control for decode, owns ID/EX valid/rd.
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module id_issue_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_REGS   = 32,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dec_valid,
  input  logic [REG_ADDR_W-1:0] dec_rd,
  input  logic [REG_ADDR_W-1:0] dec_rs1,
  input  logic [REG_ADDR_W-1:0] dec_rs2,
  input  logic                  dec_use_rs1,
  input  logic                  dec_use_rs2,
  input  logic                  dec_wr_rd,
  output logic                  id_ready,
  input  logic                  ex_ready,
  output logic                  ex_valid,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_wr_rd,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  flush,
  output logic                  stall,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [NUM_REGS-1:0]   pending,
  output logic                  wb_err
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [NUM_REGS-1:0]     pending_q, pending_d;
  logic                    ex_valid_q, ex_valid_d;
  logic [REG_ADDR_W-1:0]   ex_rd_q, ex_rd_d;
  logic                    ex_wr_rd_q, ex_wr_rd_d;
  logic [CNT_W-1:0]        stall_cnt_q, stall_cnt_d;
  logic                    wb_err_q, wb_err_d;

  logic                    hazard;
  logic                    ex_accept;
  logic                    issue_fire;
  logic                    in_flush;
  logic [NUM_REGS-1:0]     set_vec;
  logic [NUM_REGS-1:0]     clr_vec;

  function automatic logic [NUM_REGS-1:0] one_hot(input logic [REG_ADDR_W-1:0] idx);
    logic [NUM_REGS-1:0] v;
    v = '0;
    if (int'(idx) < NUM_REGS) v[idx] = 1'b1;
    return v;
  endfunction

  // A same-cycle writeback resolves the hazard; register 0 is never pending.
  function automatic logic eff_pending(input logic [REG_ADDR_W-1:0] idx);
    logic p;
    p = 1'b0;
    if (idx != '0 && int'(idx) < NUM_REGS) p = pending_q[idx];
    return p & ~(wb_valid & (wb_rd == idx));
  endfunction

  always_comb begin
    in_flush   = (state_q == ST_FLUSH);
    hazard     = dec_valid & ((dec_use_rs1 & eff_pending(dec_rs1)) |
                              (dec_use_rs2 & eff_pending(dec_rs2)) |
                              (dec_wr_rd   & eff_pending(dec_rd)));
    ex_accept  = ~ex_valid_q | ex_ready;
    issue_fire = dec_valid & ~hazard & ex_accept & ~flush & ~in_flush;
    id_ready   = issue_fire | ~dec_valid | flush | in_flush;
    stall      = dec_valid & ~id_ready;
  end

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_fire && dec_wr_rd && dec_rd != '0) set_vec = one_hot(dec_rd);
    if (wb_valid) clr_vec = one_hot(wb_rd);
    // A flushed ID/EX writer never reaches writeback, so release its bit.
    if (flush && ex_valid_q && ex_wr_rd_q && !ex_ready)
      clr_vec = clr_vec | one_hot(ex_rd_q);
    pending_d    = (pending_q & ~clr_vec) | set_vec;
    pending_d[0] = 1'b0;
  end

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_rd_d    = ex_rd_q;
    ex_wr_rd_d = ex_wr_rd_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (issue_fire) begin
      ex_valid_d = 1'b1;
      ex_rd_d    = dec_rd;
      ex_wr_rd_d = dec_wr_rd;
    end else if (ex_ready) begin
      ex_valid_d = 1'b0;
    end
  end

  always_comb begin
    wb_err_d = wb_err_q;
    if (wb_valid && wb_rd != '0) begin
      if (int'(wb_rd) >= NUM_REGS) wb_err_d = 1'b1;
      else if (!pending_q[wb_rd]) wb_err_d = 1'b1;
    end
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_FLUSH;
    end else begin
      case (state_q)
        ST_RUN:   state_d = stall ? ST_STALL : ST_RUN;
        ST_STALL: state_d = stall ? ST_STALL : ST_RUN;
        ST_FLUSH: state_d = ST_RUN;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      pending_q   <= '0;
      ex_valid_q  <= 1'b0;
      ex_rd_q     <= '0;
      ex_wr_rd_q  <= 1'b0;
      stall_cnt_q <= '0;
      wb_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      ex_valid_q  <= ex_valid_d;
      ex_rd_q     <= ex_rd_d;
      ex_wr_rd_q  <= ex_wr_rd_d;
      stall_cnt_q <= stall_cnt_d;
      wb_err_q    <= wb_err_d;
    end
  end

  assign ex_valid  = ex_valid_q;
  assign ex_rd     = ex_rd_q;
  assign ex_wr_rd  = ex_wr_rd_q;
  assign stall_cnt = stall_cnt_q;
  assign pending   = pending_q;
  assign wb_err    = wb_err_q;

endmodule
`default_nettype wire

// File: tb/tb_id_issue_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_id_issue_ctrl : directed + random stimulus against a per-register model.
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module tb_id_issue_ctrl;

  localparam int AW = 5;
  localparam int NR = 32;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          dec_valid, dec_use_rs1, dec_use_rs2, dec_wr_rd;
  logic [AW-1:0] dec_rd, dec_rs1, dec_rs2;
  logic          id_ready, ex_ready, ex_valid, ex_wr_rd;
  logic [AW-1:0] ex_rd;
  logic          wb_valid;
  logic [AW-1:0] wb_rd;
  logic          flush, stall, wb_err;
  logic [CW-1:0] stall_cnt;
  logic [NR-1:0] pending;

  int checks = 0;
  int errors = 0;

  // Reference state: per-register pending flags, ID/EX slot, and whether
  // the previous cycle carried a flush (that is the drop-one-cycle window).
  bit          m_pend[NR];
  bit          m_exv, m_exwr, m_infl, m_err;
  int          m_exrd, m_cnt;

  always #5 clk = ~clk;

  id_issue_ctrl #(.REG_ADDR_W(AW), .NUM_REGS(NR), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_wr_rd(dec_wr_rd),
    .id_ready(id_ready), .ex_ready(ex_ready), .ex_valid(ex_valid),
    .ex_rd(ex_rd), .ex_wr_rd(ex_wr_rd), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .flush(flush), .stall(stall), .stall_cnt(stall_cnt), .pending(pending),
    .wb_err(wb_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit eff(input int r);
    return (r != 0) && m_pend[r] && !(wb_valid && int'(wb_rd) == r);
  endfunction

  task automatic drv(input bit v, input int rd, input int rs1, input int rs2,
                     input bit u1, input bit u2, input bit wr, input bit exr,
                     input bit wbv, input int wbrd, input bit fl, input bit r);
    dec_valid = v; dec_rd = AW'(rd); dec_rs1 = AW'(rs1); dec_rs2 = AW'(rs2);
    dec_use_rs1 = u1; dec_use_rs2 = u2; dec_wr_rd = wr; ex_ready = exr;
    wb_valid = wbv; wb_rd = AW'(wbrd); flush = fl; rst = r;
  endtask

  // Check one cycle against the model, then advance the model across the edge.
  task automatic step();
    bit hz, acc, fire, idr, stl, clr, st;
    bit nxt[NR];
    logic [31:0] pv;
    @(negedge clk);
    hz   = dec_valid && ((dec_use_rs1 && eff(int'(dec_rs1))) ||
                         (dec_use_rs2 && eff(int'(dec_rs2))) ||
                         (dec_wr_rd   && eff(int'(dec_rd))));
    acc  = !m_exv || ex_ready;
    fire = dec_valid && !hz && acc && !flush && !m_infl;
    idr  = fire || !dec_valid || flush || m_infl;
    stl  = dec_valid && !idr;
    pv = '0;
    for (int i = 0; i < NR; i++) pv[i] = m_pend[i];
    check("id_ready",  32'(id_ready),  32'(idr));
    check("stall",     32'(stall),     32'(stl));
    check("ex_valid",  32'(ex_valid),  32'(m_exv));
    if (m_exv) begin
      check("ex_rd",    32'(ex_rd),    32'(m_exrd));
      check("ex_wr_rd", 32'(ex_wr_rd), 32'(m_exwr));
    end
    check("pending",   32'(pending),   pv);
    check("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    check("wb_err",    32'(wb_err),    32'(m_err));

    if (rst) begin
      for (int i = 0; i < NR; i++) m_pend[i] = 0;
      m_exv = 0; m_exwr = 0; m_exrd = 0; m_infl = 0; m_cnt = 0; m_err = 0;
    end else begin
      if (wb_valid && wb_rd != 0 && !m_pend[int'(wb_rd)]) m_err = 1;
      for (int i = 0; i < NR; i++) begin
        clr = (wb_valid && int'(wb_rd) == i) ||
              (flush && m_exv && m_exwr && !ex_ready && m_exrd == i);
        st  = fire && dec_wr_rd && int'(dec_rd) == i && i != 0;
        nxt[i] = st || (m_pend[i] && !clr);
      end
      for (int i = 0; i < NR; i++) m_pend[i] = nxt[i];
      if (flush) m_exv = 0;
      else if (fire) begin m_exv = 1; m_exrd = int'(dec_rd); m_exwr = dec_wr_rd; end
      else if (ex_ready) m_exv = 0;
      if (stl && m_cnt < CNT_MAX) m_cnt++;
      m_infl = flush;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) m_pend[i] = 0;
    m_exv = 0; m_exwr = 0; m_exrd = 0; m_infl = 0; m_cnt = 0; m_err = 0;
    drv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    @(posedge clk); #1;
    step(); step();

    // RAW on r5: three stall cycles, then same-cycle writeback releases it
    drv(1, 5, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0); step();
    drv(1, 6, 5, 0, 1, 0, 1, 1, 0, 0, 0, 0); repeat (3) step();
    drv(1, 6, 5, 0, 1, 0, 1, 1, 1, 5, 0, 0); step();
    drv(0, 0, 0, 0, 0, 0, 0, 1, 1, 6, 0, 0); step();

    // WAW on r7: writeback cycle issues the new writer, bit stays set
    drv(1, 7, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0); step();
    drv(1, 7, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0); repeat (2) step();
    drv(1, 7, 0, 0, 0, 0, 1, 1, 1, 7, 0, 0); step();
    drv(0, 0, 0, 0, 0, 0, 0, 1, 1, 7, 0, 0); step();

    // Backpressure with a hazard-free follower
    drv(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    drv(1, 4, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0); repeat (2) step();
    drv(1, 4, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0); step();
    drv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0); step();

    // Flush kills an un-accepted r3 writer and releases pending[3]
    drv(1, 3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0); step();
    drv(1, 8, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0); step();
    drv(1, 8, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0); step();
    drv(1, 8, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0); step();
    drv(0, 0, 0, 0, 0, 0, 0, 1, 1, 8, 0, 0); step();

    // r0 writer and reader, then a spurious writeback to r9
    drv(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0); step();
    drv(1, 1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0); step();
    drv(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0); step();
    drv(0, 0, 0, 0, 0, 0, 0, 1, 1, 9, 0, 0); step();
    drv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0); repeat (2) step();

    // Long hazard saturates the counter; reset lands mid-stall
    drv(1, 10, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0); step();
    drv(1, 11, 10, 0, 1, 0, 1, 1, 0, 0, 0, 0); repeat (20) step();
    drv(1, 11, 10, 0, 1, 0, 1, 1, 0, 0, 0, 1); step();
    drv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0); step();

    for (int n = 0; n < 3000; n++) begin
      drv($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
          $urandom_range(0, 7), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
          $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
          $urandom_range(0, 2) == 0, $urandom_range(0, 7),
          $urandom_range(0, 15) == 0, $urandom_range(0, 79) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
